// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the 16-requester round-robin arbiter:
//   N_REQ / IDX_W  - requester count and index width
//   state_t        - arbiter FSM states
//   next_idx()     - circular successor of a requester index
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Requester after idx, wrapping N_REQ-1 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        if (idx == IDX_W'(N_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + IDX_W'(1);
        end
        return nxt;
    endfunction

endpackage : rr_arb_pkg

// File: rtl/onehot_enc16.sv
// ---------------------------------------------------------------------------
// onehot_enc16
// Combinational 16-to-4 one-hot to binary encoder. Same function as the
// downstream encoder datapath, so grant_idx always matches what that
// datapath would compute from the grant vector.
//   onehot  in  16  one-hot (or all-zero) vector
//   idx     out 4   binary index of the set bit; 0 when onehot is zero
// ---------------------------------------------------------------------------
module onehot_enc16
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx
);

    // Output bit gi is the OR of every input line whose index has bit gi set.
    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bit
            logic [N_REQ-1:0] mask;
            for (genvar gj = 0; gj < N_REQ; gj++) begin : g_mask
                assign mask[gj] = ((gj >> gi) & 1) != 0;
            end
            assign idx[gi] = |(onehot & mask);
        end
    endgenerate

endmodule : onehot_enc16

// File: rtl/rr_arbiter16.sv
// ---------------------------------------------------------------------------
// rr_arbiter16
// Round-robin arbiter sharing one resource among 16 requesters. A grant is
// held until the owner drops its request, or (MAX_HOLD != 0) until it has
// been held MAX_HOLD cycles. The pointer moves to owner+1 on every release
// so the previous owner gets the lowest priority next time.
//   MAX_HOLD     param  max grant length in cycles; 0 disables preemption
//   clock        in  1  rising-edge clock
//   reset_n      in  1  asynchronous active-low reset
//   enable       in  1  allows new grants (does not revoke a held grant)
//   req          in  16 request lines
//   grant        out 16 registered one-hot grant, zero when idle
//   grant_idx    out 4  binary index of the owner, 0 when idle
//   grant_valid  out 1  high while a grant is held
//   preempt      out 1  one-cycle pulse after a timeout revoke
// ---------------------------------------------------------------------------
module rr_arbiter16
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit PREEMPT_EN = (MAX_HOLD > 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [CNT_W-1:0] hold_cnt_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [IDX_W-1:0] grant_idx_reg;
    logic             grant_valid_reg;
    logic             preempt_reg;

    logic [N_REQ-1:0] req_rot;
    logic [N_REQ-1:0] pick_rot;
    logic [N_REQ-1:0] winner_oh;
    logic [IDX_W-1:0] winner_idx;
    logic             owner_req;

    // Rotate so that bit ptr lands at position 0. The 4-bit index sum wraps
    // modulo 16 on its own.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign req_rot[gi] = req[IDX_W'(gi) + ptr_reg];
        end
    endgenerate

    // Lowest set bit of the rotated vector: x & (-x).
    assign pick_rot = req_rot & (~req_rot + N_REQ'(1));

    // Rotate the winner back into requester numbering.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unrot
            assign winner_oh[gi] = pick_rot[IDX_W'(gi) - ptr_reg];
        end
    endgenerate

    onehot_enc16 u_enc (
        .onehot (winner_oh),
        .idx    (winner_idx)
    );

    assign owner_req = req[grant_idx_reg];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            hold_cnt_reg    <= '0;
            grant_reg       <= '0;
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
            preempt_reg     <= 1'b0;
        end else begin
            preempt_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (enable && (|req)) begin
                        state_reg       <= GRANT;
                        grant_reg       <= winner_oh;
                        grant_idx_reg   <= winner_idx;
                        grant_valid_reg <= 1'b1;
                        hold_cnt_reg    <= '0;
                    end
                end
                GRANT: begin
                    // Release is checked first so it wins over a coincident timeout.
                    if (!owner_req || (PREEMPT_EN && (hold_cnt_reg == HOLD_LAST))) begin
                        state_reg       <= IDLE;
                        grant_reg       <= '0;
                        grant_idx_reg   <= '0;
                        grant_valid_reg <= 1'b0;
                        hold_cnt_reg    <= '0;
                        ptr_reg         <= next_idx(grant_idx_reg);
                        preempt_reg     <= owner_req;
                    end else if (hold_cnt_reg != '1) begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = grant_idx_reg;
    assign grant_valid = grant_valid_reg;
    assign preempt     = preempt_reg;

endmodule : rr_arbiter16

// File: tb/tb_rr_arbiter16.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter16
// Two arbiters: dut_a with MAX_HOLD=0 (no preemption) and dut_b with
// MAX_HOLD=4. Each step drives one arbiter's inputs at the falling edge and
// queues the outputs expected after the next rising edge; a monitor pops
// and compares them 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_rr_arbiter16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        en_a = 1'b1, en_b = 1'b1;
    logic [15:0] req_a = '0, req_b = '0;
    logic [15:0] grant_a, grant_b;
    logic [3:0]  idx_a, idx_b;
    logic        valid_a, valid_b;
    logic        pre_a, pre_b;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct {
        bit          sel;
        logic [15:0] req;
        bit          en;
        bit          valid;
        logic [3:0]  idx;
        bit          pre;
        int          tag;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clock = ~clock;

    rr_arbiter16 #(.MAX_HOLD(0)) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (en_a),
        .req         (req_a),
        .grant       (grant_a),
        .grant_idx   (idx_a),
        .grant_valid (valid_a),
        .preempt     (pre_a)
    );

    rr_arbiter16 #(.MAX_HOLD(4)) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (en_b),
        .req         (req_b),
        .grant       (grant_b),
        .grant_idx   (idx_b),
        .grant_valid (valid_b),
        .preempt     (pre_b)
    );

    task automatic chk(input string nm, input int tag, input logic [31:0] act,
                       input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, tag, act, req_v);
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic step(input bit s, input logic [15:0] r, input bit e,
                        input bit v, input logic [3:0] i, input bit p);
        vec_t rec;
        if (s == 1'b0) begin
            req_a = r;
            en_a  = e;
        end else begin
            req_b = r;
            en_b  = e;
        end
        rec = '{sel: s, req: r, en: e, valid: v, idx: i, pre: p, tag: step_no};
        step_no++;
        exp_q.push_back(rec);
        $display("step %0d: dut_%s req=%h en=%0d -> expect valid=%0d idx=%0d preempt=%0d",
                 rec.tag, s ? "b" : "a", r, e, v, i, p);
        @(negedge clock);
    endtask

    function automatic void add(input bit s, input logic [15:0] r, input bit e,
                                input bit v, input logic [3:0] i, input bit p);
        vecs.push_back('{sel: s, req: r, en: e, valid: v, idx: i, pre: p, tag: 0});
    endfunction

    // Scoreboard monitor.
    initial begin
        vec_t        e;
        logic [15:0] g;
        logic [15:0] exp_g;
        logic [3:0]  ix;
        logic        vl;
        logic        pr;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.sel == 1'b0) begin
                    g = grant_a; ix = idx_a; vl = valid_a; pr = pre_a;
                end else begin
                    g = grant_b; ix = idx_b; vl = valid_b; pr = pre_b;
                end
                exp_g = e.valid ? (16'h0001 << e.idx) : 16'h0000;
                chk("grant",       e.tag, 32'(g),  32'(exp_g));
                chk("grant_idx",   e.tag, 32'(ix), 32'(e.valid ? e.idx : 4'd0));
                chk("grant_valid", e.tag, 32'(vl), 32'(e.valid));
                chk("preempt",     e.tag, 32'(pr), 32'(e.pre));
            end
        end
    end

    initial begin
        logic [15:0] all_but;

        // Wrap-around on dut_a: previous owner 14 puts ptr at 15.
        add(0, 16'h4000, 1, 1, 14, 0);
        add(0, 16'h0000, 1, 0,  0, 0);
        add(0, 16'h8001, 1, 1, 15, 0);
        add(0, 16'h0001, 1, 0,  0, 0);
        add(0, 16'h0001, 1, 1,  0, 0);
        add(0, 16'h0000, 1, 0,  0, 0);
        add(0, 16'h0003, 1, 1,  1, 0);   // ptr is 1 after owner 0
        add(0, 16'h0000, 1, 0,  0, 0);
        // Hold and release: req[2] rising does not disturb owner 4.
        for (int k = 0; k < 4; k++) add(0, 16'h0010, 1, 1, 4, 0);
        for (int k = 0; k < 3; k++) add(0, 16'h0014, 1, 1, 4, 0);
        add(0, 16'h0004, 1, 0,  0, 0);
        add(0, 16'h0004, 1, 1,  2, 0);
        add(0, 16'h0000, 1, 0,  0, 0);
        // Enable gating.
        add(0, 16'h0100, 0, 0,  0, 0);
        add(0, 16'h0100, 0, 0,  0, 0);
        add(0, 16'h0100, 1, 1,  8, 0);
        add(0, 16'h0100, 0, 1,  8, 0);
        add(0, 16'h0100, 0, 1,  8, 0);
        add(0, 16'h0000, 0, 0,  0, 0);
        add(0, 16'h0100, 0, 0,  0, 0);
        add(0, 16'h0100, 1, 1,  8, 0);   // left granted for the reset pulse

        // Reset state.
        repeat (2) @(negedge clock);
        chk("rst grant_a", -1, 32'(grant_a), 32'h0);
        chk("rst idx_a",   -1, 32'(idx_a),   32'h0);
        chk("rst valid_a", -1, 32'(valid_a), 32'h0);
        chk("rst pre_a",   -1, 32'(pre_a),   32'h0);
        chk("rst grant_b", -1, 32'(grant_b), 32'h0);
        chk("rst valid_b", -1, 32'(valid_b), 32'h0);
        reset_n = 1'b1;

        // Fairness: every requester asks, each owner releases after one cycle.
        for (int k = 0; k < 16; k++) begin
            all_but = 16'hFFFF & ~(16'h0001 << k);
            step(0, 16'hFFFF, 1, 1, 4'(k), 0);
            step(0, all_but,  1, 0, 0, 0);
        end
        step(0, 16'hFFFF, 1, 1, 0, 0);
        step(0, 16'hFFFE, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].sel, vecs[i].req, vecs[i].en, vecs[i].valid, vecs[i].idx, vecs[i].pre);
        end

        // Asynchronous reset pulse between edges while dut_a holds a grant.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async grant_a", -2, 32'(grant_a), 32'h0);
        chk("async idx_a",   -2, 32'(idx_a),   32'h0);
        chk("async valid_a", -2, 32'(valid_a), 32'h0);
        chk("async pre_a",   -2, 32'(pre_a),   32'h0);
        req_a = 16'h0000;
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        // ptr back at 0: requester 8 beats 9 (ptr 9 would pick 9).
        step(0, 16'h0300, 1, 1, 8, 0);
        step(0, 16'h0000, 1, 0, 0, 0);

        // Preemption on dut_b (MAX_HOLD=4).
        step(1, 16'h0080, 1, 1, 7, 0);
        for (int k = 0; k < 3; k++) step(1, 16'h0088, 1, 1, 7, 0);
        step(1, 16'h0088, 1, 0, 0, 1);
        step(1, 16'h0088, 1, 1, 3, 0);   // 7 now lowest priority
        step(1, 16'h0080, 1, 0, 0, 0);
        step(1, 16'h0080, 1, 1, 7, 0);
        for (int k = 0; k < 3; k++) step(1, 16'h0080, 1, 1, 7, 0);
        step(1, 16'h0000, 1, 0, 0, 0);   // release on the last cycle: no preempt
        step(1, 16'h0000, 1, 0, 0, 0);

        repeat (2) @(negedge clock);
        chk("queue drained", -3, 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rr_arbiter16
